// File: rtl/exposure_ctrl_fsm.sv
// Exposure and readout sequencer for the pixel array: erase, expose for a
// latched and clamped number of cycles, then read row 1 and row 2 through the ADC.
module exposure_ctrl_fsm #(
    parameter logic [4:0] EXP_MIN   = 5'd2,
    parameter logic [4:0] EXP_MAX   = 5'd30,
    parameter logic [7:0] NRE_SETUP = 8'd1,
    parameter logic [7:0] ADC_PULSE = 8'd1,
    parameter logic [7:0] NRE_HOLD  = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [4:0] ex_time,
    output logic       Erase,
    output logic       Expose,
    output logic       NRE_1,
    output logic       NRE_2,
    output logic       ADC,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, EXPOSE, READ1, READ2} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

    state_t     state, state_next;
    phase_t     phase, phase_next;
    logic [7:0] step, step_next;
    logic [4:0] exp_cnt, exp_cnt_next;
    logic       done_q, done_next;
    logic [4:0] t_clamped;
    logic [7:0] phase_len;

    always_comb begin
        if (ex_time < EXP_MIN) begin
            t_clamped = EXP_MIN;
        end else if (ex_time > EXP_MAX) begin
            t_clamped = EXP_MAX;
        end else begin
            t_clamped = ex_time;
        end
    end

    always_comb begin
        case (phase)
            SETUP:   phase_len = NRE_SETUP;
            PULSE:   phase_len = ADC_PULSE;
            default: phase_len = NRE_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            phase   <= SETUP;
            step    <= 8'd0;
            exp_cnt <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            step    <= step_next;
            exp_cnt <= exp_cnt_next;
            done_q  <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase;
        step_next    = step;
        exp_cnt_next = exp_cnt;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    state_next   = EXPOSE;
                    exp_cnt_next = t_clamped;
                    phase_next   = SETUP;
                    step_next    = 8'd0;
                end
            end
            EXPOSE: begin
                // Leave on a count of 1 so the counter never decrements past it.
                if (exp_cnt <= 5'd1) begin
                    state_next   = READ1;
                    phase_next   = SETUP;
                    step_next    = 8'd0;
                    exp_cnt_next = 5'd0;
                end else begin
                    exp_cnt_next = exp_cnt - 5'd1;
                end
            end
            READ1, READ2: begin
                if (step + 8'd1 >= phase_len) begin
                    step_next = 8'd0;
                    case (phase)
                        SETUP: phase_next = PULSE;
                        PULSE: phase_next = HOLD;
                        default: begin
                            phase_next = SETUP;
                            if (state == READ1) begin
                                state_next = READ2;
                            end else begin
                                state_next = IDLE;
                                done_next  = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    step_next = step + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Erase  = (state == IDLE);
    assign Expose = (state == EXPOSE);
    assign NRE_1  = (state != READ1);
    assign NRE_2  = (state != READ2);
    assign ADC    = ((state == READ1) || (state == READ2)) && (phase == PULSE);
    assign busy   = (state != IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_exposure_ctrl_fsm.sv
// Directed bench for exposure_ctrl_fsm: per-cycle output traces of each frame
// are compared against a timeline model built from the exposure time T.
module tb_exposure_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic       init;
    logic [4:0] ex_time;
    logic       Erase, Expose, NRE_1, NRE_2, ADC, busy, done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] tr [7];
    string sig_name [7] = '{"Expose", "Erase", "NRE_1", "NRE_2", "ADC", "busy", "done"};

    exposure_ctrl_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .ex_time (ex_time),
        .Erase   (Erase),
        .Expose  (Expose),
        .NRE_1   (NRE_1),
        .NRE_2   (NRE_2),
        .ADC     (ADC),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected level of a signal at cycles 1..n after the init edge; with rep
    // set, the frame repeats with period T+7 (init held high).
    function automatic logic [63:0] model_vec(input int sig, input int t, input int n, input bit rep);
        logic [63:0] v;
        int p;
        logic b;
        v = 64'd0;
        for (int k = 1; k <= n; k++) begin
            p = rep ? ((k - 1) % (t + 7)) + 1 : k;
            case (sig)
                0:       b = (p <= t);
                1:       b = (p >= t + 7);
                2:       b = !((p >= t + 1) && (p <= t + 3));
                3:       b = !((p >= t + 4) && (p <= t + 6));
                4:       b = (p == t + 2) || (p == t + 5);
                5:       b = (p <= t + 6);
                default: b = (p == t + 7);
            endcase
            v[k[5:0]] = b;
        end
        return v;
    endfunction

    task automatic start_frame(input logic [4:0] ex);
        @(negedge clk);
        ex_time = ex;
        init    = 1'b1;
        @(negedge clk);
    endtask

    task automatic capture(input int n, input logic [63:0] init_mask,
                           input int poke_cycle, input logic [4:0] poke_val);
        for (int s = 0; s < 7; s++) tr[s] = 64'd0;
        for (int k = 1; k <= n; k++) begin
            tr[0][k[5:0]] = Expose;
            tr[1][k[5:0]] = Erase;
            tr[2][k[5:0]] = NRE_1;
            tr[3][k[5:0]] = NRE_2;
            tr[4][k[5:0]] = ADC;
            tr[5][k[5:0]] = busy;
            tr[6][k[5:0]] = done;
            init = init_mask[k[5:0]];
            if (k == poke_cycle) ex_time = poke_val;
            @(negedge clk);
        end
        init = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        init    = 1'b0;
        ex_time = 5'd0;
        #12;
        n_checks++;
        if ({Erase, Expose, NRE_1, NRE_2, ADC, busy, done} !== 7'b1011000) begin
            n_fails++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {Erase, Expose, NRE_1, NRE_2, ADC, busy, done}, 7'b1011000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        capture(5, 64'd0, 0, 5'd0);
        n_checks++;
        if (tr[1] !== 64'h3E) begin
            n_fails++;
            $display("FAIL reset_idle_erase got=%h exp=%h", tr[1], 64'h3E);
        end
        n_checks++;
        if ((tr[5] | tr[6]) !== 64'd0) begin
            n_fails++;
            $display("FAIL reset_idle_busy_done got=%h exp=0", tr[5] | tr[6]);
        end
    endtask

    task automatic test_default_frame();
        start_frame(5'd15);
        capture(25, 64'd0, 0, 5'd0);
        for (int s = 0; s < 7; s++) begin
            n_checks++;
            if (tr[s] !== model_vec(s, 15, 25, 1'b0)) begin
                n_fails++;
                $display("FAIL default_frame %s got=%h exp=%h", sig_name[s], tr[s], model_vec(s, 15, 25, 1'b0));
            end
        end
    endtask

    task automatic test_clamp();
        logic [4:0] cl_in [5];
        int cl_t [5];
        cl_in = '{5'd0, 5'd1, 5'd2, 5'd30, 5'd31};
        cl_t  = '{2, 2, 2, 30, 30};
        for (int i = 0; i < 5; i++) begin
            start_frame(cl_in[i]);
            capture(cl_t[i] + 9, 64'd0, 0, 5'd0);
            for (int s = 0; s < 7; s++) begin
                n_checks++;
                if (tr[s] !== model_vec(s, cl_t[i], cl_t[i] + 9, 1'b0)) begin
                    n_fails++;
                    $display("FAIL clamp ex_time=%0d %s got=%h exp=%h", cl_in[i], sig_name[s],
                             tr[s], model_vec(s, cl_t[i], cl_t[i] + 9, 1'b0));
                end
            end
        end
    endtask

    task automatic test_latch_stability();
        start_frame(5'd10);
        capture(20, 64'd0, 3, 5'd25);
        for (int s = 0; s < 7; s++) begin
            n_checks++;
            if (tr[s] !== model_vec(s, 10, 20, 1'b0)) begin
                n_fails++;
                $display("FAIL latch_stability %s got=%h exp=%h", sig_name[s], tr[s], model_vec(s, 10, 20, 1'b0));
            end
        end
    endtask

    task automatic test_init_while_busy();
        logic [63:0] mask;
        mask = 64'd0;
        mask[4]  = 1'b1;
        mask[13] = 1'b1;
        start_frame(5'd8);
        capture(24, mask, 0, 5'd0);
        for (int s = 0; s < 7; s++) begin
            n_checks++;
            if (tr[s] !== model_vec(s, 8, 24, 1'b0)) begin
                n_fails++;
                $display("FAIL init_while_busy %s got=%h exp=%h", sig_name[s], tr[s], model_vec(s, 8, 24, 1'b0));
            end
        end
    endtask

    task automatic test_async_reset();
        start_frame(5'd4);
        init = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (NRE_1 !== 1'b0) begin
            n_fails++;
            $display("FAIL async_pre_read1 NRE_1 got=%b exp=0", NRE_1);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({Erase, Expose, NRE_1, NRE_2, ADC, busy} !== 6'b101100) begin
            n_fails++;
            $display("FAIL async_reset_immediate got=%b exp=%b",
                     {Erase, Expose, NRE_1, NRE_2, ADC, busy}, 6'b101100);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        capture(10, 64'd0, 0, 5'd0);
        n_checks++;
        if (tr[1] !== 64'h7FE) begin
            n_fails++;
            $display("FAIL async_after_erase got=%h exp=%h", tr[1], 64'h7FE);
        end
        n_checks++;
        if ((tr[0] | tr[4] | tr[5] | tr[6]) !== 64'd0) begin
            n_fails++;
            $display("FAIL async_after_active got=%h exp=0", tr[0] | tr[4] | tr[5] | tr[6]);
        end
        n_checks++;
        if ((tr[2] & tr[3]) !== 64'h7FE) begin
            n_fails++;
            $display("FAIL async_after_nre got=%h exp=%h", tr[2] & tr[3], 64'h7FE);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(5'd2);
        capture(30, ~64'd0, 0, 5'd0);
        for (int s = 0; s < 7; s++) begin
            n_checks++;
            if (tr[s] !== model_vec(s, 2, 30, 1'b1)) begin
                n_fails++;
                $display("FAIL back_to_back %s got=%h exp=%h", sig_name[s], tr[s], model_vec(s, 2, 30, 1'b1));
            end
        end
        n_checks++;
        if (tr[6] !== 64'h0804_0200) begin
            n_fails++;
            $display("FAIL back_to_back_done_spacing got=%h exp=%h", tr[6], 64'h0804_0200);
        end
        n_checks++;
        if (((~tr[2]) & (~tr[3]) & 64'h7FFF_FFFE) !== 64'd0) begin
            n_fails++;
            $display("FAIL back_to_back_nre_overlap got=%h exp=0", (~tr[2]) & (~tr[3]) & 64'h7FFF_FFFE);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_clamp();
        test_latch_stability();
        test_init_while_busy();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
